// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU, the branch unit and
// the load/store buffer. Each producer owns a one-entry holding slot. A
// round-robin pointer picks one candidate per cycle into a registered broadcast.
// Optional feature macro: CDB_BYPASS_EN. When it is defined, an empty slot
// offers the live producer input as its candidate, which gives 1-edge latency.
// Handshake: a producer result transfers on a rising edge where valid and
// ready are both high. The producer holds valid/tag/data stable until then.
// ready never depends on the producer's own valid, so there is no loop.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              branch_valid,
    input  logic [TAG_W-1:0]  branch_tag,
    input  logic [DATA_W-1:0] branch_data,
    output logic              branch_ready,
    input  logic              lsbuf_valid,
    input  logic [TAG_W-1:0]  lsbuf_tag,
    input  logic [DATA_W-1:0] lsbuf_data,
    output logic              lsbuf_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src,
    output logic [1:0]        dbg_rr
);

    // Source index: 0 = ALU, 1 = branch, 2 = LSBuf.
    logic [2:0]        w_in_valid;
    logic [TAG_W-1:0]  w_in_tag  [3];
    logic [DATA_W-1:0] w_in_data [3];

    logic [2:0]        r_slot_v;
    logic [TAG_W-1:0]  r_slot_tag  [3];
    logic [DATA_W-1:0] r_slot_data [3];

    logic [2:0]        w_cand_v;
    logic [TAG_W-1:0]  w_cand_tag  [3];
    logic [DATA_W-1:0] w_cand_data [3];

    logic [2:0]        w_grant;
    logic [1:0]        w_win;
    logic              w_any;
    logic [2:0]        w_ready;
    logic [2:0]        w_accept;
    logic [2:0]        w_bypass_win;

    logic [1:0]        r_rr;
    logic [1:0]        w_rr_next;

    function automatic logic [1:0] rr_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign w_in_valid   = {lsbuf_valid, branch_valid, alu_valid};
    assign w_in_tag[0]  = alu_tag;
    assign w_in_tag[1]  = branch_tag;
    assign w_in_tag[2]  = lsbuf_tag;
    assign w_in_data[0] = alu_data;
    assign w_in_data[1] = branch_data;
    assign w_in_data[2] = lsbuf_data;

    // Candidate per source: the held slot, or (bypass build) the live input when the slot is empty.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
`ifdef CDB_BYPASS_EN
            w_cand_v[i]    = r_slot_v[i] | w_in_valid[i];
            w_cand_tag[i]  = r_slot_v[i] ? r_slot_tag[i]  : w_in_tag[i];
            w_cand_data[i] = r_slot_v[i] ? r_slot_data[i] : w_in_data[i];
`else
            w_cand_v[i]    = r_slot_v[i];
            w_cand_tag[i]  = r_slot_tag[i];
            w_cand_data[i] = r_slot_data[i];
`endif
        end
    end

    // Round-robin pick: scan from r_rr upward, first candidate wins.
    always_comb begin
        logic [1:0] idx;
        w_grant = '0;
        w_win   = 2'd0;
        w_any   = 1'b0;
        idx     = r_rr;
        for (int k = 0; k < 3; k++) begin
            if (!w_any && w_cand_v[idx]) begin
                w_grant[idx] = 1'b1;
                w_win        = idx;
                w_any        = 1'b1;
            end
            idx = rr_inc(idx);
        end
    end

    // Ready/accept: an empty slot, or one draining this cycle, can take a new result.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_ready[i]      = rst & ~flush & (~r_slot_v[i] | w_grant[i]);
            w_accept[i]     = w_in_valid[i] & w_ready[i];
            // A grant to an empty slot means the live input went straight to the bus.
            w_bypass_win[i] = w_grant[i] & ~r_slot_v[i];
        end
    end

    assign alu_ready    = w_ready[0];
    assign branch_ready = w_ready[1];
    assign lsbuf_ready  = w_ready[2];

    // Holding slots: drain on grant, refill on accept (refill wins when both happen).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_v <= '0;
            for (int i = 0; i < 3; i++) begin
                r_slot_tag[i]  <= '0;
                r_slot_data[i] <= '0;
            end
        end else if (flush) begin
            r_slot_v <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_accept[i] && !w_bypass_win[i]) begin
                    r_slot_v[i]    <= 1'b1;
                    r_slot_tag[i]  <= w_in_tag[i];
                    r_slot_data[i] <= w_in_data[i];
                end else if (w_grant[i]) begin
                    r_slot_v[i] <= 1'b0;
                end
            end
        end
    end

    // Broadcast register: one-cycle valid pulse per grant; payload holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= 2'd0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (w_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= w_cand_tag[w_win];
            cdb_data  <= w_cand_data[w_win];
            cdb_src   <= w_win;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    // Round-robin pointer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr <= 2'd0;
        end else begin
            r_rr <= w_rr_next;
        end
    end

    // Pointer next state: one past the winner; frozen on flush or when idle.
    always_comb begin
        w_rr_next = r_rr;
        if (!flush && w_any) begin
            w_rr_next = rr_inc(w_win);
        end
    end

    // Pointer output: exposed for observation.
    always_comb begin
        dbg_rr = r_rr;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model of the CDB arbiter.
module tb_cdb_arbiter;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int EW     = 2 + TAG_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              alu_valid = 1'b0, branch_valid = 1'b0, lsbuf_valid = 1'b0;
    logic [TAG_W-1:0]  alu_tag = '0, branch_tag = '0, lsbuf_tag = '0;
    logic [DATA_W-1:0] alu_data = '0, branch_data = '0, lsbuf_data = '0;
    logic              alu_ready, branch_ready, lsbuf_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        cdb_src;
    logic [1:0]        dbg_rr;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data), .alu_ready(alu_ready),
        .branch_valid(branch_valid), .branch_tag(branch_tag), .branch_data(branch_data),
        .branch_ready(branch_ready),
        .lsbuf_valid(lsbuf_valid), .lsbuf_tag(lsbuf_tag), .lsbuf_data(lsbuf_data),
        .lsbuf_ready(lsbuf_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
        .dbg_rr(dbg_rr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] readies();
        return {lsbuf_ready, branch_ready, alu_ready};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] v, input logic [TAG_W-1:0] t0, t1, t2,
                         input logic [DATA_W-1:0] d0, d1, d2, input logic fl);
        alu_valid = v[0]; alu_tag = t0; alu_data = d0;
        branch_valid = v[1]; branch_tag = t1; branch_data = d1;
        lsbuf_valid = v[2]; lsbuf_tag = t2; lsbuf_data = d2;
        flush = fl;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        drive(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
        #1;
        chk({name, " rst cdb_valid"}, {63'd0, cdb_valid}, 64'd0);
        chk({name, " rst ready"}, {61'd0, readies()}, 64'd0);
        chk({name, " rst cdb_tag/src"}, {58'd0, cdb_src, cdb_tag}, 64'd0);
        chk({name, " rst rr"}, {62'd0, dbg_rr}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] tdata(input logic [TAG_W-1:0] t);
        return {28'hD000000, t};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic             pre_reset;
        logic [2:0]       v;
        logic [TAG_W-1:0] t0, t1, t2;
        logic             fl;
        logic [2:0]       exp_ready;
        logic             exp_cv;
        logic [TAG_W-1:0] exp_tag;
        logic [1:0]       exp_src;
        logic [1:0]       exp_rr;
    } vec_t;

    function automatic vec_t mk(input logic pr, input logic [2:0] v, input logic [TAG_W-1:0] t0, t1, t2,
                                input logic fl, input logic [2:0] er, input logic cv,
                                input logic [TAG_W-1:0] et, input logic [1:0] es, input logic [1:0] err);
        vec_t r;
        r.pre_reset = pr; r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.fl = fl;
        r.exp_ready = er; r.exp_cv = cv; r.exp_tag = et; r.exp_src = es; r.exp_rr = err;
        return r;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     held;
    logic [2:0]        m_v;
    logic [TAG_W-1:0]  m_tag  [3];
    logic [DATA_W-1:0] m_data [3];
    int                m_rr;

    logic [2:0]        in_v;
    logic [TAG_W-1:0]  in_tag  [3];
    logic [DATA_W-1:0] in_data [3];
    logic              in_fl;

    task automatic model_reset();
        exp_q.delete();
        held = '0;
        m_v  = '0;
        m_rr = 0;
        for (int i = 0; i < 3; i++) begin
            m_tag[i] = '0; m_data[i] = '0;
        end
    endtask

    task automatic model_eval(output logic [2:0] rdy, output int g);
        logic [2:0] cand;
        cand = m_v;
`ifdef CDB_BYPASS_EN
        cand = m_v | in_v;
`endif
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (m_rr + k) % 3;
            if (g < 0 && cand[s]) g = s;
        end
        for (int i = 0; i < 3; i++) rdy[i] = !in_fl && (!m_v[i] || g == i);
    endtask

    task automatic model_commit(input logic [2:0] rdy, input int g);
        logic [2:0] old_v;
        old_v = m_v;
        if (in_fl) begin
            m_v = '0;
        end else begin
            if (g >= 0) begin
                if (old_v[g]) exp_q.push_back({2'(g), m_tag[g], m_data[g]});
                else          exp_q.push_back({2'(g), in_tag[g], in_data[g]});
                m_rr = (g + 1) % 3;
                m_v[g] = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (in_v[i] && rdy[i] && !(g == i && !old_v[i])) begin
                    m_v[i] = 1'b1; m_tag[i] = in_tag[i]; m_data[i] = in_data[i];
                end
            end
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[$];
    logic [2:0] pend;
    logic [2:0] m_rdy;
    int         g;
    int         lat;
    logic       seen;

    initial begin
        do_reset("init");

`ifndef CDB_BYPASS_EN
        // Single ALU result, 2-edge latency.
        @(negedge clk);
        drive(3'b001, 4'd5, '0, '0, 32'h12345678, '0, '0, 1'b0);
        #1 chk("single alu_ready", {63'd0, alu_ready}, 64'd1);
        @(posedge clk); #1;
        chk("single cdb_valid early", {63'd0, cdb_valid}, 64'd0);
        @(negedge clk);
        drive(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        chk("single cdb_valid", {63'd0, cdb_valid}, 64'd1);
        chk("single cdb_tag", {60'd0, cdb_tag}, 64'd5);
        chk("single cdb_data", {32'd0, cdb_data}, 64'h12345678);
        chk("single cdb_src", {62'd0, cdb_src}, 64'd0);
        @(posedge clk); #1;
        chk("single pulse end", {63'd0, cdb_valid}, 64'd0);
        chk("single tag hold", {60'd0, cdb_tag}, 64'd5);

        // Three-way contention, ALU stream vs held branch result, flush.
        vecs.push_back(mk(1, 3'b111, 1, 2, 3, 0, 3'b111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 1, 2, 3, 0, 3'b001, 1, 1, 0, 1));
        vecs.push_back(mk(0, 3'b000, 1, 2, 3, 0, 3'b011, 1, 2, 1, 2));
        vecs.push_back(mk(0, 3'b000, 1, 2, 3, 0, 3'b111, 1, 3, 2, 0));
        vecs.push_back(mk(0, 3'b000, 1, 2, 3, 0, 3'b111, 0, 3, 2, 0));
        vecs.push_back(mk(1, 3'b011, 1, 9, 0, 0, 3'b111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 2, 9, 0, 0, 3'b101, 1, 1, 0, 1));
        vecs.push_back(mk(0, 3'b001, 3, 9, 0, 0, 3'b110, 1, 9, 1, 2));
        vecs.push_back(mk(0, 3'b001, 3, 9, 0, 0, 3'b111, 1, 2, 0, 1));
        vecs.push_back(mk(0, 3'b000, 3, 9, 0, 0, 3'b111, 1, 3, 0, 1));
        vecs.push_back(mk(0, 3'b000, 3, 9, 0, 0, 3'b111, 0, 3, 0, 1));
        vecs.push_back(mk(1, 3'b111, 4, 5, 6, 0, 3'b111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4, 5, 6, 1, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4, 5, 6, 0, 3'b111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4, 5, 6, 0, 3'b111, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            logic [DATA_W-1:0] ed;
            if (vecs[i].pre_reset) do_reset($sformatf("vec%0d", i));
            @(negedge clk);
            drive(vecs[i].v, vecs[i].t0, vecs[i].t1, vecs[i].t2,
                  tdata(vecs[i].t0), tdata(vecs[i].t1), tdata(vecs[i].t2), vecs[i].fl);
            #1 chk($sformatf("vec%0d ready", i), {61'd0, readies()}, {61'd0, vecs[i].exp_ready});
            @(posedge clk); #1;
            ed = (vecs[i].exp_tag == '0) ? '0 : tdata(vecs[i].exp_tag);
            chk($sformatf("vec%0d cdb_valid", i), {63'd0, cdb_valid}, {63'd0, vecs[i].exp_cv});
            chk($sformatf("vec%0d cdb_tag", i), {60'd0, cdb_tag}, {60'd0, vecs[i].exp_tag});
            chk($sformatf("vec%0d cdb_data", i), {32'd0, cdb_data}, {32'd0, ed});
            chk($sformatf("vec%0d cdb_src", i), {62'd0, cdb_src}, {62'd0, vecs[i].exp_src});
            chk($sformatf("vec%0d rr", i), {62'd0, dbg_rr}, {62'd0, vecs[i].exp_rr});
        end
`else
        // Lone LSBuf result bypasses straight onto the bus.
        @(negedge clk);
        drive(3'b100, '0, '0, 4'd7, '0, '0, 32'hFF, 1'b0);
        #1 chk("byp lsbuf_ready", {63'd0, lsbuf_ready}, 64'd1);
        @(posedge clk); #1;
        chk("byp cdb_valid", {63'd0, cdb_valid}, 64'd1);
        chk("byp cdb_tag", {60'd0, cdb_tag}, 64'd7);
        chk("byp cdb_data", {32'd0, cdb_data}, 64'hFF);
        chk("byp cdb_src", {62'd0, cdb_src}, 64'd2);
        @(negedge clk);
        drive(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        chk("byp no repeat", {63'd0, cdb_valid}, 64'd0);
`endif

        // Asynchronous reset with full slots and a broadcast in flight.
        do_reset("async");
        @(negedge clk);
        drive(3'b111, 4'd7, 4'd8, 4'd9, tdata(7), tdata(8), tdata(9), 1'b0);
        @(negedge clk);
        drive(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        chk("async pre cdb_valid", {63'd0, cdb_valid}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async cdb_valid", {63'd0, cdb_valid}, 64'd0);
        chk("async ready", {61'd0, readies()}, 64'd0);
        chk("async cdb_tag", {60'd0, cdb_tag}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("async no stale", {63'd0, cdb_valid}, 64'd0);
        end
        @(negedge clk);
        drive(3'b010, '0, 4'hA, '0, '0, tdata(4'hA), '0, 1'b0);
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                @(negedge clk);
                drive(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
            end
            if (!seen && cdb_valid) begin
                seen = 1'b1;
                lat = i;
                chk("async first tag", {60'd0, cdb_tag}, 64'hA);
                chk("async first src", {62'd0, cdb_src}, 64'd1);
            end
        end
`ifdef CDB_BYPASS_EN
        chk("async latency", lat, 64'd1);
`else
        chk("async latency", lat, 64'd2);
`endif

        // Randomized run against the reference model.
        do_reset("rand");
        model_reset();
        pend = '0;
        in_fl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_tag[i] = '0; in_data[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("rand cdb_valid", {63'd0, cdb_valid}, 64'd1);
                chk("rand cdb payload", {26'd0, cdb_src, cdb_tag, cdb_data}, {26'd0, e});
                held = e;
            end else begin
                chk("rand cdb_valid", {63'd0, cdb_valid}, 64'd0);
                chk("rand cdb hold", {26'd0, cdb_src, cdb_tag, cdb_data}, {26'd0, held});
            end
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    in_tag[i] = 4'($urandom_range(1, 15));
                    in_data[i] = $urandom;
                end
            end
            in_v = pend;
            in_fl = ($urandom_range(0, 19) == 0);
            drive(in_v, in_tag[0], in_tag[1], in_tag[2], in_data[0], in_data[1], in_data[2], in_fl);
            model_eval(m_rdy, g);
            #1 chk("rand ready", {61'd0, readies()}, {61'd0, m_rdy});
            @(posedge clk);
            model_commit(m_rdy, g);
            for (int i = 0; i < 3; i++) if (pend[i] && m_rdy[i]) pend[i] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single ROB/reservation-station common data bus (CDB) between the three result producers: ALU, branch unit and load/store buffer. Each producer hands over one `{tag, data}` result through a valid/ready handshake into a one-entry holding slot. A round-robin arbiter picks one occupied slot per cycle and drives a registered broadcast that feeds the ROB write port and the tag-match logic of the reservation stations.

## Interface
Parameters:
- `TAG_W`, 4, result tag width (`tagWidth`); tag 0 is `tagFree`.
- `DATA_W`, 32, result data width (`dataWidth`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous pipeline flush (mispredict).
- `alu_valid`, `branch_valid`, `lsbuf_valid`  in  1 each  producer has a result.
- `alu_tag`, `branch_tag`, `lsbuf_tag`  in  TAG_W each  result tag.
- `alu_data`, `branch_data`, `lsbuf_data`  in  DATA_W each  result value.
- `alu_ready`, `branch_ready`, `lsbuf_ready`  out  1 each  arbiter accepts this cycle.
- `cdb_valid`  out  1  broadcast valid, one-cycle pulse per result.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `cdb_data`  out  DATA_W  broadcast data.
- `cdb_src`  out  2  winner: 0 = ALU, 1 = branch, 2 = LSBuf.

## Operation
- Source index: ALU = 0, branch = 1, LSBuf = 2. Each source has one slot `{slot_v, slot_tag, slot_data}`.
- Candidate for source i:
  - the slot, if `slot_v[i]` is set;
  - otherwise nothing (see Configuration for the bypass case).
- Round-robin pointer `rr` takes values 0..2.
  - Priority order is rr, (rr+1) mod 3, (rr+2) mod 3.
  - The first source with a candidate gets `grant[i]`.
- `ready[i] = rst & ~flush & (~slot_v[i] | grant[i])`. This is combinational, so a full slot can be refilled in the same cycle it drains.
- Rising edge, no flush:
  - Output register loads the granted candidate: `cdb_valid` = 1, `cdb_src` = i.
  - If there is no grant, `cdb_valid` = 0 and `cdb_tag`/`cdb_data`/`cdb_src` hold their previous values.
  - `rr` <= (i+1) mod 3 on a grant; unchanged otherwise.
  - Each slot is cleared if granted. Independently, it is loaded if `valid[i] & ready[i]`.
- Rising edge with `flush` = 1:
  - All `slot_v` and `cdb_valid` are cleared.
  - No input is accepted and `rr` is unchanged.
  - Flush overrides grant and accept.
- No backpressure from the ROB; every broadcast is consumed.
- Per-source ordering is preserved. While a source's slot is occupied, its new result waits in the slot and never overtakes it.
- A producer must hold `valid`/`tag`/`data` stable until `ready` is seen high.

## Timing
- Reset (asynchronous, while `rst` = 0):
  - `cdb_valid`, `cdb_tag`, `cdb_data`, `cdb_src`, `rr` and all `slot_v`/`slot_tag`/`slot_data` are 0.
  - All `ready` = 0.
- Reset asserted mid-operation discards slot contents and any pending broadcast immediately.
- Latency without bypass, uncontended:
  - result accepted at edge N;
  - broadcast visible after edge N+1 for exactly one cycle.
- Throughput: one broadcast per cycle. The worst-case wait for a slot with a candidate is 2 cycles (three-way contention).
- Steady three-way contention grants the sources in rotation, e.g. 0, 1, 2, 0, …
- A full slot not granted holds `ready` = 0. The producer stalls.
- `rr` wraps from 2 to 0.
- Simultaneous refill and drain of the same slot: the old entry is broadcast and the new entry is stored, both on the same edge.

## Configuration
- `CDB_BYPASS_EN` defined:
  - An empty slot's candidate is the live input (`valid[i]`, `tag[i]`, `data[i]`).
  - A bypass winner goes straight into the output register and its slot stays empty. Uncontended latency is 1 edge (accept at N, broadcast after N).
  - A bypass loser is written into its slot as usual.
- Not defined: candidates are slots only; latency is 2 edges as above.
- Ready equation, flush and round-robin rules are identical in both builds.

## Test plan
- Single ALU result, tag 5, data 0x1234_5678, `rr` = 0, no bypass:
  - `alu_ready` = 1 at accept;
  - one-cycle `cdb_valid` one edge later with tag 5, data 0x12345678, `cdb_src` = 0.
- All three sources valid on the same cycle, tags 1/2/3, `rr` = 0:
  - broadcasts on three consecutive cycles with tags 1, 2, 3 and `cdb_src` 0, 1, 2;
  - `rr` ends at 0.
- ALU issues tags 1, 2, 3 back-to-back while branch holds a result with tag 9:
  - ALU and branch are granted alternately;
  - `alu_ready` drops to 0 on the cycles its full slot is not granted;
  - ALU order is 1, 2, 3 and the tag 9 result is broadcast once.
- Fill all three slots, then assert `flush` for one cycle:
  - all readies = 0 during flush;
  - `cdb_valid` = 0 on the next cycle and no stale tag is ever broadcast.
- Drive `rst` low asynchronously mid-cycle with slots full:
  - `cdb_valid` and readies go to 0 immediately, without waiting for a clock edge;
  - after release the first broadcast is a newly accepted result.
- With `CDB_BYPASS_EN`, a lone LSBuf result (tag 7, data 0xFF):
  - broadcast on the edge it is accepted (1-edge latency), `cdb_src` = 2;
  - `lsbuf` slot remains empty.
